// File: rtl/l1_mem_ctrl_if.sv
// Cache-side and memory-side signal bundle for l1_mem_ctrl.
// The controller uses the slave view; the environment (cache + memory) uses the master view.
interface l1_mem_ctrl_if #(
   parameter int unsigned AW = 32
);
   logic          fill_req;
   logic [AW-1:0] fill_addr;
   logic          fill_ready;
   logic          fill_valid;
   logic [255:0]  fill_data;

   logic          wb_req;
   logic [AW-1:0] wb_addr;
   logic [31:0]   wb_be;
   logic [255:0]  wb_data;
   logic          wb_ready;

   logic [AW-1:0] mem_a;
   logic          mem_read;
   logic          mem_write;
   logic [31:0]   mem_be;
   logic [255:0]  mem_wd;
   logic [255:0]  mem_rd;
   logic          mem_valid;

   logic          idle;

   modport slave (
      input  fill_req, fill_addr, wb_req, wb_addr, wb_be, wb_data, mem_rd, mem_valid,
      output fill_ready, fill_valid, fill_data, wb_ready, mem_a, mem_read, mem_write,
             mem_be, mem_wd, idle
   );

   modport master (
      output fill_req, fill_addr, wb_req, wb_addr, wb_be, wb_data, mem_rd, mem_valid,
      input  fill_ready, fill_valid, fill_data, wb_ready, mem_a, mem_read, mem_write,
             mem_be, mem_wd, idle
   );
endinterface

// File: rtl/l1_mem_ctrl.sv
// L1 memory-side controller: one outstanding line fill plus an in-order writeback FIFO,
// sequenced onto the memory address/data-phase protocol.
module l1_mem_ctrl #(
   parameter int unsigned WB_DEPTH = 4,
   parameter int unsigned AW       = 32
) (
   input logic          clk,
   input logic          reset,
   l1_mem_ctrl_if.slave bus
);
   localparam int unsigned PW = $clog2(WB_DEPTH);

   typedef enum logic [2:0] {StIdle, StWrA, StWrD, StRdA, StRdW1, StRdW2} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] fifo_addr [WB_DEPTH];
   logic [31:0]   fifo_be   [WB_DEPTH];
   logic [255:0]  fifo_data [WB_DEPTH];
   logic [PW:0]   wr_ptr_q, rd_ptr_q, count;
   logic [PW-1:0] offs;
   logic          full, empty, push, pop, hazard;
   logic          fill_pend_q, fill_accept, fill_done;
   logic [AW-1:0] fill_addr_q;
   logic [31:0]   wr_be_q;
   logic [255:0]  wr_data_q;

   assign count = wr_ptr_q - rd_ptr_q;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
   assign push  = bus.wb_req && !full;

   assign fill_accept = bus.fill_req && !fill_pend_q;
   assign fill_done   = (state_q == StRdW2) && bus.mem_valid;

   assign bus.fill_ready = !fill_pend_q;
   assign bus.wb_ready   = !full;
   assign bus.idle       = empty && !fill_pend_q && (state_q == StIdle);

   // An entry is live when its distance from the read pointer is below the fill level.
   always_comb begin
      hazard = 1'b0;
      offs   = '0;
      for (int unsigned i = 0; i < WB_DEPTH; i++) begin
         offs = PW'(i) - rd_ptr_q[PW-1:0];
         if (fill_pend_q && ({1'b0, offs} < count) && (fifo_addr[i] == fill_addr_q)) begin
            hazard = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         StIdle: begin
            if (fill_pend_q && !hazard) begin
               state_d = StRdA;
            end else if (!empty) begin
               state_d = StWrA;
               pop     = 1'b1;
            end
         end
         StWrA:   state_d = StWrD;
         StWrD:   state_d = StIdle;
         StRdA:   state_d = StRdW1;
         StRdW1:  state_d = StRdW2;
         StRdW2:  if (bus.mem_valid) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr_q[PW-1:0]] <= bus.wb_addr;
         fifo_be[wr_ptr_q[PW-1:0]]   <= bus.wb_be;
         fifo_data[wr_ptr_q[PW-1:0]] <= bus.wb_data;
      end
   end

   // Memory-side outputs are registered and decoded from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         fill_pend_q    <= 1'b0;
         fill_addr_q    <= '0;
         wr_be_q        <= '0;
         wr_data_q      <= '0;
         bus.fill_valid <= 1'b0;
         bus.fill_data  <= '0;
         bus.mem_a      <= '0;
         bus.mem_read   <= 1'b0;
         bus.mem_write  <= 1'b0;
         bus.mem_be     <= '0;
         bus.mem_wd     <= '0;
      end else begin
         state_q <= state_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

         if (fill_accept) begin
            fill_pend_q <= 1'b1;
            fill_addr_q <= bus.fill_addr;
         end else if (fill_done) begin
            fill_pend_q <= 1'b0;
         end
         bus.fill_valid <= fill_done;
         if (fill_done) bus.fill_data <= bus.mem_rd;

         // The popped entry is held here while the head slot may be overwritten.
         if (pop) begin
            bus.mem_a <= fifo_addr[rd_ptr_q[PW-1:0]];
            wr_be_q   <= fifo_be[rd_ptr_q[PW-1:0]];
            wr_data_q <= fifo_data[rd_ptr_q[PW-1:0]];
         end else if (state_d == StRdA) begin
            bus.mem_a <= fill_addr_q;
         end
         bus.mem_read  <= (state_d == StRdA);
         bus.mem_write <= (state_d == StWrD);
         bus.mem_be    <= (state_d == StWrD) ? wr_be_q : '0;
         bus.mem_wd    <= (state_d == StWrD) ? wr_data_q : '0;
      end
   end
endmodule

// File: tb/tb_l1_mem_ctrl.sv
// Self-checking bench for l1_mem_ctrl: table-driven transactions plus timed corner sequences,
// with a small memory model and write/fill scoreboards.
module tb_l1_mem_ctrl;
   localparam int unsigned AW = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   l1_mem_ctrl_if #(.AW(AW)) bus ();

   l1_mem_ctrl #(.WB_DEPTH(4), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Memory model: read data returns two cycles after the address phase.
   logic [255:0] ram [32];
   logic         pre_we;
   logic [4:0]   pre_addr;
   logic [255:0] pre_data;
   logic         rd_s1, rd_s2;
   logic [4:0]   rd_a1, rd_a2;

   always_ff @(posedge clk) begin
      rd_s1 <= bus.mem_read;
      rd_a1 <= bus.mem_a[4:0];
      rd_s2 <= rd_s1;
      rd_a2 <= rd_a1;
      if (pre_we) begin
         ram[pre_addr] <= pre_data;
      end else if (bus.mem_write) begin
         for (int b = 0; b < 32; b++) begin
            if (bus.mem_be[b]) ram[bus.mem_a[4:0]][b*8 +: 8] <= bus.mem_wd[b*8 +: 8];
         end
      end
   end

   assign bus.mem_valid = rd_s2;
   assign bus.mem_rd    = rd_s2 ? ram[rd_a2] : {8{32'hDEADBEEF}};

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   be;
      logic [255:0]  data;
   } wr_t;

   typedef struct packed {
      logic          is_wb;
      logic [AW-1:0] addr;
      logic [31:0]   be;
      logic [255:0]  data;
      logic [255:0]  exp;
   } vec_t;

   wr_t          exp_wr_q [$];
   logic [255:0] exp_fill_q [$];
   int           tests = 0;
   int           fails = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Scoreboard consumer: every memory write and every returned fill is matched in order.
   initial begin
      wr_t          e;
      logic [255:0] f;
      forever begin
         @(negedge clk);
         if (!reset && bus.mem_write) begin
            if (exp_wr_q.size() == 0) begin
               chk1("unexpected mem_write", bus.mem_write, 1'b0);
            end else begin
               e = exp_wr_q.pop_front();
               chk32("wr mem_a", bus.mem_a, e.addr);
               chk32("wr mem_be", bus.mem_be, e.be);
               chk256("wr mem_wd", bus.mem_wd, e.data);
            end
         end
         if (!reset && bus.fill_valid) begin
            if (exp_fill_q.size() == 0) begin
               chk1("unexpected fill_valid", bus.fill_valid, 1'b0);
            end else begin
               f = exp_fill_q.pop_front();
               chk256("fill_data", bus.fill_data, f);
            end
         end
      end
   end

   task automatic preload(input logic [4:0] a, input logic [255:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic send_wb(input logic [AW-1:0] a, input logic [31:0] be, input logic [255:0] d);
      int n = 0;
      bus.wb_req  = 1'b1;
      bus.wb_addr = a;
      bus.wb_be   = be;
      bus.wb_data = d;
      while (!bus.wb_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk1("wb accept", bus.wb_ready, 1'b1);
      if (bus.wb_ready) exp_wr_q.push_back('{addr: a, be: be, data: d});
      @(negedge clk);
      bus.wb_req = 1'b0;
   endtask

   task automatic send_fill(input logic [AW-1:0] a, input logic [255:0] e);
      int n = 0;
      bus.fill_req  = 1'b1;
      bus.fill_addr = a;
      while (!bus.fill_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk1("fill accept", bus.fill_ready, 1'b1);
      if (bus.fill_ready) exp_fill_q.push_back(e);
      @(negedge clk);
      bus.fill_req = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (!(bus.idle && exp_wr_q.size() == 0 && exp_fill_q.size() == 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n >= 300) begin
         fails++;
         $display("FAIL drain timeout: idle=%b wr_left=%0d fill_left=%0d",
                  bus.idle, exp_wr_q.size(), exp_fill_q.size());
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk1({tag, " fill_ready"}, bus.fill_ready, 1'b1);
      chk1({tag, " wb_ready"}, bus.wb_ready, 1'b1);
      chk1({tag, " idle"}, bus.idle, 1'b1);
      chk1({tag, " fill_valid"}, bus.fill_valid, 1'b0);
      chk256({tag, " fill_data"}, bus.fill_data, '0);
      chk32({tag, " mem_a"}, bus.mem_a, '0);
      chk1({tag, " mem_read"}, bus.mem_read, 1'b0);
      chk1({tag, " mem_write"}, bus.mem_write, 1'b0);
      chk32({tag, " mem_be"}, bus.mem_be, '0);
      chk256({tag, " mem_wd"}, bus.mem_wd, '0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [10];
      int   idx;

      vecs[0] = '{is_wb: 1'b0, addr: 32'd5, be: '0, data: '0, exp: {32{8'hA5}}};
      vecs[1] = '{is_wb: 1'b1, addr: 32'd4, be: 32'hFFFFFFFF, data: {8{32'h0BADF00D}}, exp: '0};
      vecs[2] = '{is_wb: 1'b0, addr: 32'd4, be: '0, data: '0, exp: {8{32'h0BADF00D}}};
      vecs[3] = '{is_wb: 1'b1, addr: 32'd1, be: 32'h0000FFFF, data: {8{32'h55AA55AA}}, exp: '0};
      vecs[4] = '{is_wb: 1'b0, addr: 32'd1, be: '0, data: '0,
                  exp: {{4{32'h11111111}}, {4{32'h55AA55AA}}}};
      vecs[5] = '{is_wb: 1'b1, addr: 32'd6, be: 32'h00000001, data: {32{8'h11}}, exp: '0};
      vecs[6] = '{is_wb: 1'b1, addr: 32'd6, be: 32'h00000002, data: {32{8'h22}}, exp: '0};
      vecs[7] = '{is_wb: 1'b0, addr: 32'd6, be: '0, data: '0, exp: {240'b0, 8'h22, 8'h11}};
      vecs[8] = '{is_wb: 1'b1, addr: 32'd2, be: 32'h80000001, data: {8{32'hCAFEF00D}}, exp: '0};
      vecs[9] = '{is_wb: 1'b0, addr: 32'd2, be: '0, data: '0, exp: {8'hCA, 240'b0, 8'h0D}};

      reset         = 1'b1;
      pre_we        = 1'b0;
      pre_addr      = '0;
      pre_data      = '0;
      bus.fill_req  = 1'b0;
      bus.fill_addr = '0;
      bus.wb_req    = 1'b0;
      bus.wb_addr   = '0;
      bus.wb_be     = '0;
      bus.wb_data   = '0;

      @(negedge clk);
      preload(5'd5, {32{8'hA5}});
      preload(5'd1, {8{32'h11111111}});
      preload(5'd20, {8{32'h20202020}});
      preload(5'd7, '0);
      preload(5'd6, '0);
      preload(5'd2, '0);
      chk_reset_state("por");
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].is_wb) send_wb(vecs[i].addr, vecs[i].be, vecs[i].data);
         else send_fill(vecs[i].addr, vecs[i].exp);
      end
      drain();

      // Fill timing with no contention.
      bus.fill_req  = 1'b1;
      bus.fill_addr = 32'd5;
      exp_fill_q.push_back({32{8'hA5}});
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         bus.fill_req = 1'b0;
         if (k <= 4) chk1($sformatf("fill busy c%0d", k), bus.fill_ready, 1'b0);
         if (k == 2) begin
            chk1("fill mem_read c2", bus.mem_read, 1'b1);
            chk32("fill mem_a c2", bus.mem_a, 32'd5);
         end
         if (k == 3) chk1("fill mem_read c3", bus.mem_read, 1'b0);
         if (k == 5) begin
            chk1("fill_valid c5", bus.fill_valid, 1'b1);
            chk1("fill_ready c5", bus.fill_ready, 1'b1);
         end
      end
      drain();

      // Writeback then fill of the same line.
      bus.wb_req  = 1'b1;
      bus.wb_addr = 32'd3;
      bus.wb_be   = 32'hFFFFFFFF;
      bus.wb_data = {8{32'h12345678}};
      exp_wr_q.push_back('{addr: 32'd3, be: 32'hFFFFFFFF, data: {8{32'h12345678}}});
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         bus.wb_req   = 1'b0;
         bus.fill_req = (k == 1);
         if (k == 1) begin
            bus.fill_addr = 32'd3;
            exp_fill_q.push_back({8{32'h12345678}});
         end
         if (k == 2) begin
            chk32("wb mem_a c2", bus.mem_a, 32'd3);
            chk1("wb mem_write c2", bus.mem_write, 1'b0);
         end
         if (k == 3) begin
            chk1("wb mem_write c3", bus.mem_write, 1'b1);
            chk32("wb mem_be c3", bus.mem_be, 32'hFFFFFFFF);
         end
         if (k == 4) chk1("wb mem_read c4", bus.mem_read, 1'b0);
         if (k == 5) chk1("wb mem_read c5", bus.mem_read, 1'b1);
         if (k == 8) chk1("wb fill_valid c8", bus.fill_valid, 1'b1);
      end
      drain();

      // Hazard: writeback and fill of line 7 accepted together.
      bus.wb_req    = 1'b1;
      bus.wb_addr   = 32'd7;
      bus.wb_be     = 32'h0000000F;
      bus.wb_data   = '1;
      bus.fill_req  = 1'b1;
      bus.fill_addr = 32'd7;
      exp_wr_q.push_back('{addr: 32'd7, be: 32'h0000000F, data: '1});
      exp_fill_q.push_back({224'b0, 32'hFFFFFFFF});
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         bus.wb_req   = 1'b0;
         bus.fill_req = 1'b0;
         if (k == 2) begin
            chk32("hz mem_a c2", bus.mem_a, 32'd7);
            chk1("hz mem_write c2", bus.mem_write, 1'b0);
         end
         if (k == 3) chk1("hz mem_write c3", bus.mem_write, 1'b1);
         if (k == 4) chk1("hz mem_read c4", bus.mem_read, 1'b0);
         if (k == 5) begin
            chk1("hz mem_read c5", bus.mem_read, 1'b1);
            chk32("hz mem_a c5", bus.mem_a, 32'd7);
         end
         if (k == 8) chk1("hz fill_valid c8", bus.fill_valid, 1'b1);
      end
      drain();

      // Full FIFO: a fill to line 20 holds off drains while 10..13 are pushed.
      idx = 0;
      for (int k = 0; k < 7; k++) begin
         bus.fill_req  = (k == 0);
         bus.fill_addr = 32'd20;
         bus.wb_req    = (idx < 5);
         bus.wb_addr   = 32'(10 + idx);
         bus.wb_be     = 32'hFFFFFFFF;
         bus.wb_data   = {8{32'hD0000000 + 32'(idx)}};
         chk1($sformatf("full wb_ready c%0d", k), bus.wb_ready, (k <= 3 || k == 6));
         if (k == 0) exp_fill_q.push_back({8{32'h20202020}});
         if (bus.wb_ready && bus.wb_req) begin
            exp_wr_q.push_back('{addr: bus.wb_addr, be: bus.wb_be, data: bus.wb_data});
            idx++;
         end
         @(negedge clk);
      end
      bus.wb_req   = 1'b0;
      bus.fill_req = 1'b0;
      chk32("full pushes accepted", 32'(idx), 32'd5);
      drain();

      // Reset while the fill is in RD_W1 with a writeback still queued.
      bus.fill_req  = 1'b1;
      bus.fill_addr = 32'd5;
      bus.wb_req    = 1'b1;
      bus.wb_addr   = 32'd9;
      bus.wb_be     = 32'hFFFFFFFF;
      bus.wb_data   = {8{32'h99999999}};
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         bus.fill_req = 1'b0;
         bus.wb_req   = 1'b0;
      end
      chk1("pre-reset mem_read c3", bus.mem_read, 1'b0);
      chk1("pre-reset fill_ready c3", bus.fill_ready, 1'b0);
      reset = 1'b1;
      #1;
      chk_reset_state("mid");
      exp_wr_q.delete();
      exp_fill_q.delete();
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk1($sformatf("post-reset fill_valid %0d", k), bus.fill_valid, 1'b0);
         chk1($sformatf("post-reset fill_ready %0d", k), bus.fill_ready, 1'b1);
         chk1($sformatf("post-reset idle %0d", k), bus.idle, 1'b1);
      end

      send_fill(32'd5, {32{8'hA5}});
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
